// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//
// Small first-word-fall-through instruction queue between the fetch (IF) and
// decode (ID) stages. Fetch pushes {instr, pc} pairs. Decode sees the oldest
// entry combinationally from registered state and pops it with out_ready.
// A flush (branch taken / redirect) empties the queue on the next edge.
//
// Parameters
//   DEPTH     number of entries; legal values are 2, 4 or 8 (power of two so
//             the pointers wrap naturally)
//   NOP_WORD  instruction word presented on out_instr while the queue is empty
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high; beats flush, push and pop
//   flush         discard every queued entry; beats push and pop
//   in_valid      fetch presents a valid instruction
//   in_instr      fetched instruction word
//   in_pc         PC of the fetched instruction
//   in_ready      queue can accept a push (count < DEPTH)
//   out_valid     head entry is valid (count != 0)
//   out_instr     head instruction word, NOP_WORD when empty
//   out_pc        head PC, zero when empty
//   out_ready     decode consumes the head this cycle
//   count         current occupancy, 0..DEPTH
//   bubble_count  (only with IFID_BUBBLE_COUNT_EN) saturating 16-bit count of
//                 cycles where decode was ready but the queue was empty
//
// Optional feature macro: IFID_BUBBLE_COUNT_EN
// -----------------------------------------------------------------------------
module if_id_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [31:0]            in_instr,
   input  logic [31:0]            in_pc,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_pc,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count
`ifdef IFID_BUBBLE_COUNT_EN
   ,
   output logic [15:0]            bubble_count
`endif
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Storage and state
   logic [31:0]      instr_mem [DEPTH];
   logic [31:0]      pc_mem    [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic             push;
   logic             pop;

   // Handshake: in_ready depends only on registered occupancy, so there is no
   // combinational path from out_ready back to fetch. When full, a same-cycle
   // pop does not make room for a push.
   assign in_ready  = (count_q < FULL_CNT);
   assign out_valid = (count_q != '0);

   assign push = in_valid  && in_ready  && !flush;
   assign pop  = out_valid && out_ready && !flush;

   // First-word fall-through: the head is read straight from storage.
   assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP_WORD;
   assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
   assign count     = count_q;

   // Next-state logic
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; that is what keeps this block from inferring latches.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;  // idle, or push+pop cancels out
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage
   // NOTE: the data array is deliberately not reset. Stale contents are never
   // visible because out_valid gates the outputs and reset clears the
   // pointers and count, so a write landing during reset is harmless.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= in_instr;
         pc_mem[wr_ptr_q]    <= in_pc;
      end
   end

`ifdef IFID_BUBBLE_COUNT_EN
   // Decode-starvation counter: decode ready, nothing to hand it. Only reset
   // clears it; flush does not.
   logic [15:0] bubble_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_q <= '0;
      end else if (out_ready && !out_valid && (bubble_q != 16'hFFFF)) begin
         bubble_q <= bubble_q + 16'd1;
      end
   end

   assign bubble_count = bubble_q;
`endif

endmodule
